// File: rtl/result_drain.sv
// Deskews the staggered column results of a systolic array into whole rows and buffers them in a
// first-word-fall-through FIFO. Optional output rectifier selected by macro DRAIN_RELU_EN.
module result_drain #(
  parameter int SIZE  = 4,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          res_valid,
  input  logic [SIZE*(SIZE+16)-1:0]     result,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SIZE*(SIZE+16)-1:0]     out_data,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          overflow
);
  localparam int W  = SIZE + 16;
  localparam int RW = SIZE * W;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [RW-1:0] aligned;
  logic          wr_en;

  // Column j arrives j cycles after column 0, so it is delayed SIZE-1-j cycles to line up.
  for (genvar j = 0; j < SIZE; j++) begin : g_col
    localparam int L = SIZE - 1 - j;
    if (L == 0) begin : g_pass
      assign aligned[j*W +: W] = result[j*W +: W];
    end else begin : g_dly
      logic [W-1:0] dl [L];
      always_ff @(posedge clk) begin
        dl[0] <= result[j*W +: W];
        for (int i = 1; i < L; i++) dl[i] <= dl[i-1];
      end
      assign aligned[j*W +: W] = dl[L-1];
    end
  end

  if (SIZE > 1) begin : g_vld
    logic [SIZE-2:0] vsr;
    always_ff @(posedge clk) begin
      if (rst) vsr <= '0;
      else     vsr <= (vsr << 1) | (SIZE-1)'(res_valid);
    end
    assign wr_en = vsr[SIZE-2];
  end else begin : g_novld
    assign wr_en = res_valid;
  end

  logic [RW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          full;
  logic          pop;
  logic          accept;
  logic          drop;
  logic [RW-1:0] head;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign out_valid = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign pop       = out_valid && out_ready;
  // A full FIFO still takes a row when the head leaves on the same edge.
  assign accept    = wr_en && (!full || pop);
  assign drop      = wr_en && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= aligned;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop)  rd_ptr   <= ptr_next(rd_ptr);
      if (drop) overflow <= 1'b1;
      count <= count + CW'(accept) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

`ifdef DRAIN_RELU_EN
  for (genvar j = 0; j < SIZE; j++) begin : g_relu
    assign out_data[j*W +: W] = head[j*W + W - 1] ? '0 : head[j*W +: W];
  end
`else
  assign out_data = head;
`endif

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain (SIZE=4, DEPTH=4, W=20): per-cycle vector table plus
// sequences for back-to-back, overflow, reset mid-flight and backpressure.
module tb_result_drain;
  localparam int SIZE  = 4;
  localparam int DEPTH = 4;
  localparam int W     = 20;
  localparam int RW    = 80;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          res_valid = 1'b0;
  logic [RW-1:0] result = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [RW-1:0] out_data;
  logic [2:0]    count;
  logic          overflow;

  int n_checks = 0;
  int n_fail   = 0;

  result_drain #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .res_valid(res_valid), .result(result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

`ifdef DRAIN_RELU_EN
  localparam logic [RW-1:0] RELU_ROW = {20'h00000, 20'h00000, 20'h00007, 20'h00000};
`else
  localparam logic [RW-1:0] RELU_ROW = {20'h00000, 20'hFFFFF, 20'h00007, 20'hFFFFB};
`endif

  typedef struct {
    logic          rst;
    logic          rv;
    logic [W-1:0]  l0, l1, l2, l3;
    logic          rdy;
    logic          ev;
    logic [2:0]    ec;
    logic          eo;
    logic          cd;
    logic [RW-1:0] ed;
  } vec_t;

  vec_t vec [$];

  task automatic addv(input logic r, input logic rv, input logic [W-1:0] l0, input logic [W-1:0] l1,
                      input logic [W-1:0] l2, input logic [W-1:0] l3, input logic rdy, input logic ev,
                      input logic [2:0] ec, input logic eo, input logic cd, input logic [RW-1:0] ed);
    vec_t v;
    v.rst = r; v.rv = rv; v.l0 = l0; v.l1 = l1; v.l2 = l2; v.l3 = l3; v.rdy = rdy;
    v.ev = ev; v.ec = ec; v.eo = eo; v.cd = cd; v.ed = ed;
    vec.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] lv(input int base, input int r, input int j);
    return W'(base * 4096 + r * 16 + j + 1);
  endfunction

  function automatic logic [RW-1:0] row(input int base, input int r);
    logic [RW-1:0] v;
    v = '0;
    for (int j = 0; j < SIZE; j++) v[j*W +: W] = lv(base, r, j);
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1; res_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Drives n_rows skewed rows starting at cycle 0 and consumes per the ready mode:
  // 0 never, 1 always, 2 every other cycle, 3 only in cycle 7.
  task automatic run(input string tag, input int n_rows, input int base, input int mode,
                     input int cycles, input int rx_in, output int rx_out);
    int rx;
    logic stall;
    logic [RW-1:0] hold;
    rx = rx_in;
    for (int e = 0; e < cycles; e++) begin
      res_valid = (e < n_rows);
      for (int j = 0; j < SIZE; j++) begin
        int r;
        r = e - j;
        result[j*W +: W] = (r >= 0 && r < n_rows) ? lv(base, r, j) : 20'hAAAAA;
      end
      case (mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        2:       out_ready = (e % 2 == 0);
        default: out_ready = (e == 7);
      endcase
      stall = 1'b0;
      hold  = out_data;
      if (out_valid && out_ready) begin
        chk($sformatf("%s_row%0d", tag, rx), out_data, row(base, rx));
        rx++;
      end else if (out_valid) begin
        stall = 1'b1;
      end
      tick();
      if (stall) begin
        chk($sformatf("%s_stall_valid_e%0d", tag, e), RW'(out_valid), RW'(1'b1));
        chk($sformatf("%s_stall_data_e%0d", tag, e), out_data, hold);
      end
    end
    res_valid = 1'b0;
    out_ready = 1'b0;
    rx_out = rx;
  endtask

  initial begin
    int rx;
    // rst, rv, l0..l3, rdy | valid, count, overflow, check-data, data
    addv(1'b1, 1'b1, 20'h0, 20'h0, 20'h0, 20'h0, 1'b0,  1'b0, 3'd0, 1'b0, 1'b1, '0);
    addv(1'b0, 1'b0, 20'h11, 20'h11, 20'h11, 20'h11, 1'b0,  1'b0, 3'd0, 1'b0, 1'b1, '0);
    addv(1'b0, 1'b0, 20'h11, 20'h11, 20'h11, 20'h11, 1'b0,  1'b0, 3'd0, 1'b0, 1'b1, '0);
    addv(1'b0, 1'b0, 20'h11, 20'h11, 20'h11, 20'h11, 1'b0,  1'b0, 3'd0, 1'b0, 1'b1, '0);
    addv(1'b0, 1'b1, 20'h1, 20'h77, 20'h77, 20'h77, 1'b1,  1'b0, 3'd0, 1'b0, 1'b1, '0);
    addv(1'b0, 1'b0, 20'h77, 20'h2, 20'h77, 20'h77, 1'b1,  1'b0, 3'd0, 1'b0, 1'b1, '0);
    addv(1'b0, 1'b0, 20'h77, 20'h77, 20'h3, 20'h77, 1'b1,  1'b0, 3'd0, 1'b0, 1'b1, '0);
    addv(1'b0, 1'b0, 20'h77, 20'h77, 20'h77, 20'h4, 1'b1,  1'b1, 3'd1, 1'b0, 1'b1,
         {20'h4, 20'h3, 20'h2, 20'h1});
    addv(1'b0, 1'b0, 20'h77, 20'h77, 20'h77, 20'h77, 1'b1,  1'b0, 3'd0, 1'b0, 1'b0, '0);
    addv(1'b0, 1'b1, 20'hFFFFB, 20'h55, 20'h55, 20'h55, 1'b0,  1'b0, 3'd0, 1'b0, 1'b0, '0);
    addv(1'b0, 1'b0, 20'h55, 20'h7, 20'h55, 20'h55, 1'b0,  1'b0, 3'd0, 1'b0, 1'b0, '0);
    addv(1'b0, 1'b0, 20'h55, 20'h55, 20'hFFFFF, 20'h55, 1'b0,  1'b0, 3'd0, 1'b0, 1'b0, '0);
    addv(1'b0, 1'b0, 20'h55, 20'h55, 20'h55, 20'h0, 1'b0,  1'b1, 3'd1, 1'b0, 1'b1, RELU_ROW);
    addv(1'b0, 1'b0, 20'h55, 20'h55, 20'h55, 20'h55, 1'b0,  1'b1, 3'd1, 1'b0, 1'b1, RELU_ROW);
    addv(1'b0, 1'b0, 20'h55, 20'h55, 20'h55, 20'h55, 1'b1,  1'b0, 3'd0, 1'b0, 1'b0, '0);

    for (int i = 0; i < vec.size(); i++) begin
      rst       = vec[i].rst;
      res_valid = vec[i].rv;
      result    = {vec[i].l3, vec[i].l2, vec[i].l1, vec[i].l0};
      out_ready = vec[i].rdy;
      tick();
      chk($sformatf("v%0d_valid", i), RW'(out_valid), RW'(vec[i].ev));
      chk($sformatf("v%0d_count", i), RW'(count), RW'(vec[i].ec));
      chk($sformatf("v%0d_overflow", i), RW'(overflow), RW'(vec[i].eo));
      if (vec[i].cd) chk($sformatf("v%0d_data", i), out_data, vec[i].ed);
    end

    // Back-to-back fill then drain in order.
    do_reset();
    run("b2b_fill", 4, 1, 0, 7, 0, rx);
    chk("b2b_count_full", RW'(count), RW'(3'd4));
    chk("b2b_overflow", RW'(overflow), RW'(1'b0));
    run("b2b_drain", 0, 1, 1, 6, 0, rx);
    chk("b2b_rows_rx", RW'(rx), RW'(4));
    chk("b2b_count_empty", RW'(count), RW'(3'd0));

    // Fifth row with no consumer is dropped; contents intact; flag sticky.
    do_reset();
    run("ovf_fill", 5, 2, 0, 8, 0, rx);
    chk("ovf_count", RW'(count), RW'(3'd4));
    chk("ovf_flag", RW'(overflow), RW'(1'b1));
    run("ovf_drain", 0, 2, 1, 6, 0, rx);
    chk("ovf_rows_rx", RW'(rx), RW'(4));
    chk("ovf_flag_sticky", RW'(overflow), RW'(1'b1));

    // Pop on the edge that writes into a full FIFO: no drop.
    do_reset();
    run("full_pp", 5, 3, 3, 8, 0, rx);
    chk("full_pp_count", RW'(count), RW'(3'd4));
    chk("full_pp_overflow", RW'(overflow), RW'(1'b0));
    run("full_pp_drain", 0, 3, 1, 6, rx, rx);
    chk("full_pp_rows_rx", RW'(rx), RW'(5));

    // Reset while a row is in flight.
    do_reset();
    res_valid = 1'b1; result = {20'h4, 20'h3, 20'h2, 20'h1};
    tick();
    res_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("midrst_valid_%0d", i), RW'(out_valid), RW'(1'b0));
    end
    chk("midrst_count", RW'(count), RW'(3'd0));
    chk("midrst_overflow", RW'(overflow), RW'(1'b0));

    // Backpressure with ready toggling every cycle.
    do_reset();
    run("bp", 6, 4, 2, 30, 0, rx);
    chk("bp_rows_rx", RW'(rx), RW'(6));
    chk("bp_count", RW'(count), RW'(3'd0));
    chk("bp_overflow", RW'(overflow), RW'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
